// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single matrix memory port: round-robin grant,
// request/done to level start/done conversion, and hung-transaction timeout.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_start,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              start_q, start_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              sel;

  // State and output registers; reset leaves port 0 as winner of the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      rdata_q <= '0;
      start_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      rdata_q <= rdata_d;
      start_q <= start_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic: grant selection, completion, timeout and release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    rdata_d = rdata_q;
    start_d = start_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not own the memory last wins
          sel     = (req0 && req1) ? ~last_q : req1;
          wr_d    = sel ? req1_wr    : req0_wr;
          addr_d  = sel ? req1_addr  : req0_addr;
          wdata_d = sel ? req1_wdata : req0_wdata;
          start_d = 1'b1;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        if (mem_done) begin
          // Completion takes precedence over a coincident timeout
          start_d = 1'b0;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          done0_d = gnt0_q;
          done1_d = gnt1_q;
          if (!wr_q) begin
            rdata_d = mem_rdata;
          end
          last_d  = gnt1_q;
          state_d = S_RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          start_d = 1'b0;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          err0_d  = gnt0_q;
          err1_d  = gnt1_q;
          last_d  = gnt1_q;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (!mem_done) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata     = rdata_q;
  assign mem_start = start_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT=8; stimulus and sampling on the falling edge.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req0 = 1'b0, req0_wr = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [DATA_W-1:0] req0_wdata = '0;
  logic              req1 = 1'b0, req1_wr = 1'b0;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [DATA_W-1:0] req1_wdata = '0;
  logic              gnt0, gnt1, done0, done1, err0, err1;
  logic [DATA_W-1:0] rdata;
  logic              mem_start, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_done = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1(req1), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata(rdata), .mem_start(mem_start), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, done0, done1, err0, err1, mem_start, mem_wr} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 00000000",
               {gnt0, gnt1, done0, done1, err0, err1, mem_start, mem_wr});
    end
    checks++;
    if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h, required 00 0000", mem_addr, mem_wdata);
    end
    checks++;
    if (rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rdata: got %h, required 0000", rdata);
    end
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    req0 = 1'b1; req0_wr = 1'b0; req0_addr = 8'h05; req0_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if ({mem_start, gnt0, gnt1, mem_wr} !== 4'b1100 || mem_addr !== 8'h05) begin
      errors++;
      $display("FAIL read_start: start=%b gnt0=%b gnt1=%b wr=%b addr=%h, required 1 1 0 0 05",
               mem_start, gnt0, gnt1, mem_wr, mem_addr);
    end
    req0_addr = 8'h77;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_start !== 1'b1 || mem_addr !== 8'h05 || done0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL read_hold: start=%b addr=%h done0=%b gnt1=%b, required 1 05 0 0",
               mem_start, mem_addr, done0, gnt1);
    end
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({done0, done1, err0, err1, mem_start, gnt0, gnt1} !== 7'b1000000) begin
      errors++;
      $display("FAIL read_done: done0..gnt1=%b, required 1000000",
               {done0, done1, err0, err1, mem_start, gnt0, gnt1});
    end
    checks++;
    if (rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_rdata: got %h, required beef", rdata);
    end
    req0 = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0000;
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || mem_start !== 1'b0 || rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_after: done0=%b start=%b rdata=%h, required 0 0 beef",
               done0, mem_start, rdata);
    end
  endtask

  task automatic test_write();
    req1 = 1'b1; req1_wr = 1'b1; req1_addr = 8'h12; req1_wdata = 16'h00A5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req1_addr = 8'hFF; req1_wdata = 16'hFFFF; req1_wr = 1'b0;
      end
      checks++;
      if ({mem_start, gnt1, gnt0, mem_wr, mem_addr, mem_wdata} !==
          {1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 16'h00A5}) begin
        errors++;
        $display("FAIL write_busy k=%0d: start=%b gnt1=%b gnt0=%b wr=%b addr=%h wdata=%h, required 1 1 0 1 12 00a5",
                 k, mem_start, gnt1, gnt0, mem_wr, mem_addr, mem_wdata);
      end
    end
    mem_done = 1'b1; mem_rdata = 16'h5555;
    @(negedge clk);
    checks++;
    if ({done1, done0, err1, mem_start, gnt1} !== 5'b10000 || rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_done: done1=%b done0=%b err1=%b start=%b gnt1=%b rdata=%h, required 1 0 0 0 0 beef",
               done1, done0, err1, mem_start, gnt1, rdata);
    end
    req1 = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0000;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int n;
    logic p1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b1; req0_wr = 1'b0; req0_addr = 8'h20;
    req1 = 1'b1; req1_wr = 1'b0; req1_addr = 8'h30;
    for (int t = 0; t < 4; t++) begin
      p1 = t[0];
      n = 0;
      @(negedge clk);
      while (!mem_start && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (mem_start !== 1'b1 || gnt0 !== ~p1 || gnt1 !== p1) begin
        errors++;
        $display("FAIL contention_grant t=%0d: start=%b gnt0=%b gnt1=%b, required 1 %b %b",
                 t, mem_start, gnt0, gnt1, ~p1, p1);
      end
      checks++;
      if (mem_addr !== (p1 ? 8'h30 : 8'h20)) begin
        errors++;
        $display("FAIL contention_addr t=%0d: got %h, required %h", t, mem_addr, p1 ? 8'h30 : 8'h20);
      end
      mem_rdata = 16'h1000 + 16'(t); mem_done = 1'b1;
      @(negedge clk);
      checks++;
      if ({done0, done1, err0, err1, gnt0, gnt1, mem_start} !== {~p1, p1, 5'b00000}) begin
        errors++;
        $display("FAIL contention_done t=%0d: got %b, required %b", t,
                 {done0, done1, err0, err1, gnt0, gnt1, mem_start}, {~p1, p1, 5'b00000});
      end
      if (t == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({mem_start, gnt0, gnt1, done0, done1} !== 5'b00000) begin
        errors++;
        $display("FAIL contention_release t=%0d: start,gnt0,gnt1,done0,done1=%b, required 00000",
                 t, {mem_start, gnt0, gnt1, done0, done1});
      end
      mem_done = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_start !== 1'b0) begin
        errors++;
        $display("FAIL contention_gap t=%0d: start=%b, required 0", t, mem_start);
      end
    end
  endtask

  task automatic test_timeout();
    logic bad;
    req0 = 1'b1; req0_wr = 1'b0; req0_addr = 8'h40;
    @(negedge clk);
    checks++;
    if (mem_start !== 1'b1 || gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_start: start=%b gnt0=%b, required 1 1", mem_start, gnt0);
    end
    req1 = 1'b1; req1_wr = 1'b0; req1_addr = 8'h50;
    bad = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (err0 !== 1'b0 || mem_start !== 1'b1 || done0 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: early err/done or start drop seen=%b, required 0", bad);
    end
    @(negedge clk);
    checks++;
    if ({err0, err1, done0, done1, mem_start, gnt0, gnt1} !== 7'b1000000) begin
      errors++;
      $display("FAIL timeout_err: err0,err1,done0,done1,start,gnt0,gnt1=%b, required 1000000",
               {err0, err1, done0, done1, mem_start, gnt0, gnt1});
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (err0 !== 1'b0 || mem_start !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: err0=%b start=%b, required 0 0", err0, mem_start);
    end
    @(negedge clk);
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_start !== 1'b1 || mem_addr !== 8'h50) begin
      errors++;
      $display("FAIL timeout_next: gnt1=%b gnt0=%b start=%b addr=%h, required 1 0 1 50",
               gnt1, gnt0, mem_start, mem_addr);
    end
    mem_done = 1'b1; mem_rdata = 16'h2222;
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || rdata !== 16'h2222) begin
      errors++;
      $display("FAIL timeout_next_done: done1=%b rdata=%h, required 1 2222", done1, rdata);
    end
    req1 = 1'b0; mem_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    req0 = 1'b1; req0_wr = 1'b0; req0_addr = 8'h60;
    @(negedge clk);
    checks++;
    if (mem_start !== 1'b1 || gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL tie_start: start=%b gnt0=%b, required 1 1", mem_start, gnt0);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
    end
    mem_done = 1'b1; mem_rdata = 16'hCAFE;
    @(negedge clk);
    checks++;
    if ({done0, err0, err1, mem_start} !== 4'b1000 || rdata !== 16'hCAFE) begin
      errors++;
      $display("FAIL tie_done: done0=%b err0=%b err1=%b start=%b rdata=%h, required 1 0 0 0 cafe",
               done0, err0, err1, mem_start, rdata);
    end
    req0 = 1'b0; mem_done = 1'b0;
    @(negedge clk);
    checks++;
    if (err0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL tie_after: err0=%b done0=%b, required 0 0", err0, done0);
    end
  endtask

  task automatic test_async_reset();
    req0 = 1'b1; req0_wr = 1'b1; req0_addr = 8'h70; req0_wdata = 16'h7777;
    @(negedge clk);
    checks++;
    if (mem_start !== 1'b1 || gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL areset_start: start=%b gnt0=%b, required 1 1", mem_start, gnt0);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_start, gnt0, done0, mem_wr} !== 4'b0000) begin
      errors++;
      $display("FAIL areset_clear: start=%b gnt0=%b done0=%b wr=%b, required 0 0 0 0",
               mem_start, gnt0, done0, mem_wr);
    end
    req1 = 1'b1; req1_wr = 1'b0; req1_addr = 8'h71;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_addr !== 8'h70) begin
      errors++;
      $display("FAIL areset_first: gnt0=%b gnt1=%b addr=%h, required 1 0 70", gnt0, gnt1, mem_addr);
    end
    mem_done = 1'b1;
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL areset_done: done0=%b done1=%b, required 1 0", done0, done1);
    end
    req0 = 1'b0; req1 = 1'b0; mem_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_timeout();
    test_tie();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single matrix memory port between two requesters: port 0 (instruction executor, read/write) and port 1 (matrix loader, bulk reads).
- Converts per-port request/done handshakes into the level start/done protocol of the memory module.
- Applies round-robin priority when both ports request.
- Aborts a hung transaction with a timeout.
- Sits between the top-level control FSM/loader and memory_mod.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 16, memory data width
TIMEOUT, 255, max cycles mem_start may stay high without mem_done (1..2^16-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req0  in  1  port 0 request, level, held until done0/err0
req0_wr  in  1  port 0: 1=write, 0=read
req0_addr  in  ADDR_W  port 0 address
req0_wdata  in  DATA_W  port 0 write data
req1  in  1  port 1 request, same rules as req0
req1_wr  in  1  port 1: 1=write, 0=read
req1_addr  in  ADDR_W  port 1 address
req1_wdata  in  DATA_W  port 1 write data
gnt0  out  1  high while port 0 owns the memory
gnt1  out  1  high while port 1 owns the memory
done0  out  1  one-cycle pulse, port 0 transaction complete
done1  out  1  one-cycle pulse, port 1 transaction complete
err0  out  1  one-cycle pulse, port 0 transaction timed out
err1  out  1  one-cycle pulse, port 1 transaction timed out
rdata  out  DATA_W  read data, valid in the done cycle, held until next completion
mem_start  out  1  memory start, level
mem_wr  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_done  in  1  memory done, level, drops after mem_start drops

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; rdata=0; timeout counter=0; last_owner=1, so port 0 wins the first tie.
- Only outputs are registered; no combinational path from req* to mem_*.
- States: IDLE, BUSY, RELEASE.

IDLE:
- No request: stay in IDLE.
- One request: select that port.
- Both request: select the port other than last_owner.
- On selection: latch the port's wr/addr/wdata into mem_wr/mem_addr/mem_wdata; set mem_start=1 and gntX=1; clear the counter; go to BUSY.
- Latency: req sampled in cycle N gives mem_start=1 in cycle N+1.

BUSY:
- mem_* outputs stay stable; req*_addr/wdata changes are ignored.
- mem_done=1 sampled in cycle M, in cycle M+1:
  - mem_start=0 and gntX=0.
  - doneX=1 for one cycle.
  - rdata=mem_rdata if the transaction was a read; unchanged if it was a write.
  - last_owner=X.
  - Go to RELEASE.
- Otherwise the counter increments. When the counter reaches TIMEOUT with mem_done still 0, in the next cycle:
  - mem_start=0 and gntX=0.
  - errX=1 for one cycle; doneX is not pulsed.
  - last_owner=X.
  - Go to RELEASE.
- If mem_done and timeout occur in the same cycle, done wins.

RELEASE:
- Wait until mem_done=0, then go to IDLE. No new grant is issued while mem_done=1.
- Minimum gap between transactions: 1 cycle after mem_done falls.

Other rules:
- A requester must drop reqX in the cycle after doneX/errX. If reqX is still high when the arbiter returns to IDLE, it is treated as a new request.
- Dropping reqX while in BUSY does not abort the transaction; it completes and pulses doneX.
- gnt0 and gnt1 are never both high. done0/done1/err0/err1 are mutually exclusive.
- Async reset in BUSY: all outputs clear immediately and the transaction is lost. The memory sees mem_start fall.

Test Plan:
- Single read: req0=1, wr=0, addr=0x05; memory returns 0xBEEF with mem_done 3 cycles after start. Required: mem_start rises 1 cycle after req0; done0 pulses 1 cycle after mem_done; rdata=0xBEEF; gnt1 stays 0.
- Write: req1=1, wr=1, addr=0x12, wdata=0x00A5. Required: mem_wr=1, mem_addr=0x12, mem_wdata=0x00A5 for the whole BUSY phase; done1 pulses; rdata keeps its previous value.
- Contention: req0 and req1 both held high after reset for 4 transactions. Required: grant order 0,1,0,1; no overlapping gnt; each done is followed by ≥1 idle cycle after mem_done falls.
- Timeout: TIMEOUT=8, req0 read, mem_done never asserted. Required: err0 pulses exactly 9 cycles after mem_start rises; mem_start=0; done0 never pulses; arbiter then grants a pending req1.
- Reset mid-transaction: rst=0 asynchronously during BUSY. Required: mem_start, gnt0, and done0 go to 0 without waiting for a clock edge. After rst=1 with both requests high, port 0 is granted first.
- Done/timeout tie: mem_done rises in the cycle the counter reaches TIMEOUT. Required: done pulses, err does not, rdata is updated.
